// File: rtl/vc_rr_arbiter_pkg.sv
// Shared definitions for the VC0/VC1 weighted round-robin arbiter:
// FSM encodings, VC identifiers and the saturating credit helper.
package vc_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VC0  = 2'd1,
    S_VC1  = 2'd2
  } state_t;

  typedef logic vc_id_t;
  localparam vc_id_t VC_ID_0 = 1'b0;
  localparam vc_id_t VC_ID_1 = 1'b1;

  localparam int CREDIT_W = 3;
  typedef logic [CREDIT_W-1:0] credit_t;
  localparam credit_t CREDIT_MAX = 3'd7;

  // Credit counts consecutive grants to one VC and sticks at its maximum.
  function automatic credit_t credit_inc(input credit_t c);
    return (c == CREDIT_MAX) ? CREDIT_MAX : c + credit_t'(1);
  endfunction

endpackage

// File: rtl/vc_rr_arbiter_if.sv
// FIFO-side and downstream-side signals of the VC arbiter.
// master = arbiter view, slave = FIFOs/downstream (or bench) view.
interface vc_rr_arbiter_if
  import vc_rr_arbiter_pkg::*;
#(
  parameter int data_width = 6
);

  logic                  empty_fifo_VC0;
  logic                  empty_fifo_VC1;
  logic [data_width-1:0] data_out_VC0;
  logic [data_width-1:0] data_out_VC1;
  logic                  almost_full_dest;
  logic                  rd_enable_VC0;
  logic                  rd_enable_VC1;
  logic [data_width-1:0] data_out;
  logic                  valid_out;
  vc_id_t                vc_id_out;
  logic                  idle_out;

  modport master (
    input  empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1, almost_full_dest,
    output rd_enable_VC0, rd_enable_VC1, data_out, valid_out, vc_id_out, idle_out
  );

  modport slave (
    output empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1, almost_full_dest,
    input  rd_enable_VC0, rd_enable_VC1, data_out, valid_out, vc_id_out, idle_out
  );

endinterface

// File: rtl/vc_rr_arbiter.sv
// Weighted round-robin merge of the VC0/VC1 FIFOs onto one tagged stream,
// with downstream backpressure and a 2-cycle read-to-output pipeline.
module vc_rr_arbiter
  import vc_rr_arbiter_pkg::*;
#(
  parameter int data_width = 6,
  parameter int WEIGHT_VC0 = 3,
  parameter int WEIGHT_VC1 = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  vc_rr_arbiter_if.master bus
);

  localparam credit_t WEIGHT0_C = credit_t'(WEIGHT_VC0);
  localparam credit_t WEIGHT1_C = credit_t'(WEIGHT_VC1);

  state_t                state_reg, state_next;
  credit_t               credit_reg, credit_next;
  logic                  grant0, grant1;
  logic                  rd_q_reg;
  vc_id_t                sel_q_reg;
  logic [data_width-1:0] data_out_reg;
  logic                  valid_out_reg;
  vc_id_t                vc_id_out_reg;

  logic empty0, empty1, stall;
  assign empty0 = bus.empty_fifo_VC0;
  assign empty1 = bus.empty_fifo_VC1;
  assign stall  = bus.almost_full_dest;

  // Grant / next-state logic; a stall freezes state and credit.
  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    grant0      = 1'b0;
    grant1      = 1'b0;
    if (!stall) begin
      case (state_reg)
        S_IDLE: begin
          if (!empty0) begin
            grant0      = 1'b1;
            state_next  = S_VC0;
            credit_next = credit_t'(1);
          end else if (!empty1) begin
            grant1      = 1'b1;
            state_next  = S_VC1;
            credit_next = credit_t'(1);
          end
        end
        S_VC0: begin
          if (!empty0 && (credit_reg < WEIGHT0_C || empty1)) begin
            grant0      = 1'b1;
            credit_next = credit_inc(credit_reg);
          end else if (!empty1) begin
            grant1      = 1'b1;
            state_next  = S_VC1;
            credit_next = credit_t'(1);
          end else begin
            state_next  = S_IDLE;
            credit_next = '0;
          end
        end
        S_VC1: begin
          if (!empty1 && (credit_reg < WEIGHT1_C || empty0)) begin
            grant1      = 1'b1;
            credit_next = credit_inc(credit_reg);
          end else if (!empty0) begin
            grant0      = 1'b1;
            state_next  = S_VC0;
            credit_next = credit_t'(1);
          end else begin
            state_next  = S_IDLE;
            credit_next = '0;
          end
        end
        default: begin
          state_next  = S_IDLE;
          credit_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      credit_reg <= '0;
    end else if (!init) begin
      state_reg  <= S_IDLE;
      credit_reg <= '0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
    end
  end

  // Stage 1 remembers the issued read; stage 2 captures the FIFO's read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q_reg      <= 1'b0;
      sel_q_reg     <= VC_ID_0;
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      vc_id_out_reg <= VC_ID_0;
    end else if (!init) begin
      rd_q_reg      <= 1'b0;
      sel_q_reg     <= VC_ID_0;
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      vc_id_out_reg <= VC_ID_0;
    end else begin
      rd_q_reg      <= grant0 | grant1;
      sel_q_reg     <= grant1 ? VC_ID_1 : VC_ID_0;
      valid_out_reg <= rd_q_reg;
      vc_id_out_reg <= rd_q_reg ? sel_q_reg : VC_ID_0;
      if (!rd_q_reg)
        data_out_reg <= '0;
      else if (sel_q_reg == VC_ID_1)
        data_out_reg <= bus.data_out_VC1;
      else
        data_out_reg <= bus.data_out_VC0;
    end
  end

  // Reads are suppressed combinationally while either clear is asserted.
  assign bus.rd_enable_VC0 = grant0 & reset & init;
  assign bus.rd_enable_VC1 = grant1 & reset & init;
  assign bus.data_out      = data_out_reg;
  assign bus.valid_out     = valid_out_reg;
  assign bus.vc_id_out     = vc_id_out_reg;
  assign bus.idle_out      = (state_reg == S_IDLE) && empty0 && empty1
                             && !rd_q_reg && !valid_out_reg;

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Bench for vc_rr_arbiter: queue-based FIFO models feed the DUT, and a
// run-length round-robin reference predicts every grant and output word.
module tb_vc_rr_arbiter;
  import vc_rr_arbiter_pkg::*;

  localparam int DW = 6;
  localparam int W0 = 3;
  localparam int W1 = 1;

  logic clk = 1'b0;
  logic reset;
  logic init;

  vc_rr_arbiter_if #(.data_width(DW)) bus ();

  vc_rr_arbiter #(.data_width(DW), .WEIGHT_VC0(W0), .WEIGHT_VC1(W1)) dut (
    .clk  (clk),
    .reset(reset),
    .init (init),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic          vc;
    logic [DW-1:0] d;
  } word_t;

  logic [DW-1:0] fq0[$], fq1[$];   // contents of the modelled FIFOs
  logic [DW-1:0] mq0[$], mq1[$];   // reference copy of the same words
  int    last_vc, run_len;         // VC of the current grant run (-1 = none)
  word_t g1, g2;                   // grants issued one and two cycles ago
  int    errors = 0;
  int    checks = 0;
  int    valid_seen = 0;
  int    snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int vc, input logic [DW-1:0] d);
    if (vc == 0) begin
      fq0.push_back(d);
      mq0.push_back(d);
    end else begin
      fq1.push_back(d);
      mq1.push_back(d);
    end
  endtask

  task automatic model_clear();
    last_vc = -1;
    run_len = 0;
    g1 = '0;
    g2 = '0;
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic st, input logic ini);
    logic e0, e1, pop0, pop1;
    logic [DW-1:0] p0, p1;
    word_t ng;
    int pick;
    e0 = (fq0.size() == 0);
    e1 = (fq1.size() == 0);
    bus.empty_fifo_VC0   = e0;
    bus.empty_fifo_VC1   = e1;
    bus.almost_full_dest = st;
    init = ini;
    @(negedge clk);
    check("valid_out", bus.valid_out, g2.v);
    check("data_out", bus.data_out, g2.v ? g2.d : '0);
    check("vc_id_out", bus.vc_id_out, g2.v ? g2.vc : 1'b0);
    check("idle_out", bus.idle_out, (last_vc < 0) && e0 && e1 && !g1.v && !g2.v);
    if (bus.valid_out === 1'b1) valid_seen++;

    // Reference: keep serving a VC until its weight is used up while the
    // other VC waits; a fresh start always favours VC0.
    ng = '0;
    pick = -1;
    if (ini && !st) begin
      if (!e0 && !e1) begin
        if (last_vc == 0)      pick = (run_len < W0) ? 0 : 1;
        else if (last_vc == 1) pick = (run_len < W1) ? 1 : 0;
        else                   pick = 0;
      end else if (!e0) pick = 0;
      else if (!e1)     pick = 1;
      if (pick < 0) begin
        last_vc = -1;
        run_len = 0;
      end else begin
        run_len = (pick == last_vc) ? ((run_len < 7) ? run_len + 1 : 7) : 1;
        last_vc = pick;
        ng.v  = 1'b1;
        ng.vc = (pick == 1);
        if (pick == 0 && mq0.size() > 0) ng.d = mq0.pop_front();
        if (pick == 1 && mq1.size() > 0) ng.d = mq1.pop_front();
      end
    end
    check("rd_enable_VC0", bus.rd_enable_VC0, ng.v && !ng.vc);
    check("rd_enable_VC1", bus.rd_enable_VC1, ng.v && ng.vc);

    pop0 = (bus.rd_enable_VC0 === 1'b1) && (fq0.size() > 0);
    pop1 = (bus.rd_enable_VC1 === 1'b1) && (fq1.size() > 0);
    p0 = '0;
    p1 = '0;
    if (pop0) p0 = fq0.pop_front();
    if (pop1) p1 = fq1.pop_front();
    @(posedge clk);
    #1;
    if (pop0) bus.data_out_VC0 = p0;
    if (pop1) bus.data_out_VC1 = p1;
    if (!ini) model_clear();
    else begin
      g2 = g1;
      g1 = ng;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    init  = 1'b1;
    bus.almost_full_dest = 1'b0;
    bus.empty_fifo_VC0   = 1'b0;
    bus.empty_fifo_VC1   = 1'b1;
    bus.data_out_VC0     = '0;
    bus.data_out_VC1     = '0;
    model_clear();

    // Reset state; a non-empty VC0 must still not be read during reset.
    #2;
    check("rst_valid", bus.valid_out, 1'b0);
    check("rst_data", bus.data_out, '0);
    check("rst_vc_id", bus.vc_id_out, 1'b0);
    check("rst_rd0", bus.rd_enable_VC0, 1'b0);
    bus.empty_fifo_VC0 = 1'b1;
    #1;
    check("rst_idle", bus.idle_out, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;

    // VC0 alone, words 1..4
    for (int i = 1; i <= 4; i++) push(0, DW'(i));
    run(8);

    // Both VCs loaded: 3:1 weighting
    for (int i = 0; i < 8; i++) begin
      push(0, DW'($urandom_range(0, 63)));
      push(1, DW'($urandom_range(0, 63)));
    end
    run(20);

    // Same load with a 5-cycle stall mid-burst
    for (int i = 0; i < 8; i++) begin
      push(0, DW'($urandom_range(0, 63)));
      push(1, DW'($urandom_range(0, 63)));
    end
    valid_seen = 0;
    run(5);
    snap = valid_seen;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    check("stall_drain_le2", (valid_seen - snap) <= 2, 1'b1);
    run(22);
    check("stall_word_count", valid_seen, 16);

    // Single word, then back to idle
    push(0, 6'h2a);
    run(6);
    check("single_idle", bus.idle_out, 1'b1);

    // Asynchronous reset with a read in flight
    for (int i = 0; i < 4; i++) begin
      push(0, DW'($urandom_range(0, 63)));
      push(1, DW'($urandom_range(0, 63)));
    end
    run(3);
    #2 reset = 1'b0;
    fq0.delete();
    fq1.delete();
    mq0.delete();
    mq1.delete();
    bus.empty_fifo_VC0 = 1'b1;
    bus.empty_fifo_VC1 = 1'b1;
    bus.data_out_VC0   = '0;
    bus.data_out_VC1   = '0;
    #1;
    check("arst_valid", bus.valid_out, 1'b0);
    check("arst_data", bus.data_out, '0);
    check("arst_vc_id", bus.vc_id_out, 1'b0);
    check("arst_idle", bus.idle_out, 1'b1);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    push(1, 6'h11);
    push(0, 6'h22);
    push(1, 6'h33);
    run(8);

    // Soft clear for 2 cycles with both VCs non-empty
    for (int i = 0; i < 3; i++) begin
      push(0, DW'($urandom_range(0, 63)));
      push(1, DW'($urandom_range(0, 63)));
    end
    run(2);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    run(10);

    // Random traffic, stalls and occasional soft clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 40) push(0, DW'($urandom_range(0, 63)));
      if ($urandom_range(0, 99) < 30) push(1, DW'($urandom_range(0, 63)));
      cycle(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) >= 2));
    end
    run(60);
    check("final_idle", bus.idle_out, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
